// File: rtl/filtre_cozucu.sv
// Streaming decoder for the image filter: validates 5-bit filtered codes, recovers
// the 3-bit pure-image value plus saturation flag, and buffers results in a FWFT FIFO.
module filtre_cozucu #(
    parameter int unsigned DERINLIK = 4,
    parameter int unsigned SAYAC_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               giris_gecerli,
    output logic               giris_hazir,
    input  logic [4:0]         filtrelenmis_resim,
    output logic               cikis_gecerli,
    input  logic               cikis_hazir,
    output logic [2:0]         saf_resim,
    output logic               doyma,
    output logic               hata_darbe,
    output logic [SAYAC_W-1:0] hata_sayisi,
    input  logic               sayac_temizle
);

    localparam int unsigned PTR_W   = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
    localparam int unsigned DOL_W   = PTR_W + 1;
    localparam int unsigned SAF_W   = 3;
    localparam int unsigned GIRDI_W = SAF_W + 1;

    logic [GIRDI_W-1:0] bellek [DERINLIK];
    logic [PTR_W-1:0]   yaz_ptr;
    logic [PTR_W-1:0]   oku_ptr;
    logic [DOL_W-1:0]   doluluk;

    logic               kod_yasal_c;
    logic [SAF_W-1:0]   kod_saf_c;
    logic               kod_doyma_c;
    logic               kabul_c;
    logic               yaz_c;
    logic               oku_c;
    logic               hata_c;

    // Legal output set of the forward filter; everything else is illegal.
    always_comb begin
        kod_yasal_c = 1'b0;
        kod_saf_c   = '0;
        kod_doyma_c = 1'b0;
        case (filtrelenmis_resim)
            5'd0: begin
                kod_yasal_c = 1'b1;
                kod_saf_c   = SAF_W'(0);
            end
            5'd2: begin
                kod_yasal_c = 1'b1;
                kod_saf_c   = SAF_W'(1);
            end
            5'd4: begin
                kod_yasal_c = 1'b1;
                kod_saf_c   = SAF_W'(2);
            end
            5'd6: begin
                kod_yasal_c = 1'b1;
                kod_saf_c   = SAF_W'(3);
            end
            // Sources 4..7 all collapse onto 17, so only the floor value survives.
            5'd17: begin
                kod_yasal_c = 1'b1;
                kod_saf_c   = SAF_W'(4);
                kod_doyma_c = 1'b1;
            end
            default: begin
                kod_yasal_c = 1'b0;
            end
        endcase
    end

    // Ready depends only on registered occupancy, never on the output side.
    assign giris_hazir   = (doluluk < DOL_W'(DERINLIK));
    assign cikis_gecerli = (doluluk != '0);
    assign kabul_c       = giris_gecerli && giris_hazir;
    assign yaz_c         = kabul_c && kod_yasal_c;
    assign hata_c        = kabul_c && !kod_yasal_c;
    assign oku_c         = cikis_gecerli && cikis_hazir;

    // Storage needs no reset: the head is masked whenever occupancy is zero.
    always_ff @(posedge clk) begin
        if (yaz_c) begin
            bellek[yaz_ptr] <= {kod_saf_c, kod_doyma_c};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yaz_ptr <= '0;
            oku_ptr <= '0;
        end else begin
            if (yaz_c) begin
                yaz_ptr <= yaz_ptr + PTR_W'(1);
            end
            if (oku_c) begin
                oku_ptr <= oku_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            doluluk <= '0;
        end else begin
            case ({yaz_c, oku_c})
                2'b10:   doluluk <= doluluk + DOL_W'(1);
                2'b01:   doluluk <= doluluk - DOL_W'(1);
                default: doluluk <= doluluk;
            endcase
        end
    end

    // First-word fall-through head, forced to zero while empty.
    always_comb begin
        saf_resim = '0;
        doyma     = 1'b0;
        if (cikis_gecerli) begin
            {saf_resim, doyma} = bellek[oku_ptr];
        end
    end

    // Clear wins over a same-cycle increment; the pulse still fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hata_darbe  <= 1'b0;
            hata_sayisi <= '0;
        end else begin
            hata_darbe <= hata_c;
            if (sayac_temizle) begin
                hata_sayisi <= '0;
            end else if (hata_c && (hata_sayisi != {SAYAC_W{1'b1}})) begin
                hata_sayisi <= hata_sayisi + SAYAC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_filtre_cozucu.sv
// Scoreboard bench for filtre_cozucu: queue-based reference model, randomized and
// directed traffic, plus a narrow-counter instance for saturation/clear behaviour.
module tb_filtre_cozucu;

    localparam int unsigned D  = 4;
    localparam int unsigned SW = 8;

    logic          clk;
    logic          rst_n;
    logic          giris_gecerli;
    logic          giris_hazir;
    logic [4:0]    filtrelenmis_resim;
    logic          cikis_gecerli;
    logic          cikis_hazir;
    logic [2:0]    saf_resim;
    logic          doyma;
    logic          hata_darbe;
    logic [SW-1:0] hata_sayisi;
    logic          sayac_temizle;

    logic          v2;
    logic          hz2;
    logic [4:0]    k2;
    logic          cv2;
    logic [2:0]    saf2;
    logic          doy2;
    logic          darbe2;
    logic [1:0]    sayi2;
    logic          c2;

    int            n_test;
    int            n_fail;
    logic [3:0]    exp_q[$];
    bit            model_on;
    bit            model_hazir;
    logic          exp_darbe;
    logic [SW-1:0] exp_cnt;

    filtre_cozucu #(.DERINLIK(D), .SAYAC_W(SW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .giris_gecerli(giris_gecerli), .giris_hazir(giris_hazir),
        .filtrelenmis_resim(filtrelenmis_resim),
        .cikis_gecerli(cikis_gecerli), .cikis_hazir(cikis_hazir),
        .saf_resim(saf_resim), .doyma(doyma),
        .hata_darbe(hata_darbe), .hata_sayisi(hata_sayisi),
        .sayac_temizle(sayac_temizle)
    );

    filtre_cozucu #(.DERINLIK(D), .SAYAC_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .giris_gecerli(v2), .giris_hazir(hz2),
        .filtrelenmis_resim(k2),
        .cikis_gecerli(cv2), .cikis_hazir(1'b1),
        .saf_resim(saf2), .doyma(doy2),
        .hata_darbe(darbe2), .hata_sayisi(sayi2),
        .sayac_temizle(c2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_test++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: even codes 0..6 carry value code/2, 17 marks saturation.
    function automatic bit decode(input logic [4:0] k, output logic [3:0] e);
        e = 4'd0;
        if (k == 5'd17) begin
            e = {3'd4, 1'b1};
            return 1'b1;
        end
        if (k <= 5'd6 && k[0] == 1'b0) begin
            e = {3'(k >> 1), 1'b0};
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Monitor: compare the visible state with the model, then retire a popped entry.
    always @(negedge clk) begin
        if (model_on) begin
            model_hazir = (exp_q.size() < D);
            check("giris_hazir", int'(giris_hazir), int'(model_hazir));
            check("cikis_gecerli", int'(cikis_gecerli), int'(exp_q.size() != 0));
            if (exp_q.size() != 0)
                check("head", int'({saf_resim, doyma}), int'(exp_q[0]));
            else
                check("empty_out", int'({saf_resim, doyma}), 0);
            check("hata_darbe", int'(hata_darbe), int'(exp_darbe));
            check("hata_sayisi", int'(hata_sayisi), int'(exp_cnt));
            if (exp_q.size() != 0 && cikis_hazir)
                void'(exp_q.pop_front());
        end
    end

    // Stimulus side of the scoreboard: predict what the coming edge does.
    always @(negedge clk) begin
        logic [3:0] e;
        bit         ok;
        bit         acc;
        #1;
        if (model_on) begin
            acc = giris_gecerli && model_hazir;
            ok  = decode(filtrelenmis_resim, e);
            exp_darbe = acc && !ok;
            if (sayac_temizle)
                exp_cnt = '0;
            else if (acc && !ok && exp_cnt != {SW{1'b1}})
                exp_cnt = exp_cnt + SW'(1);
            if (acc && ok)
                exp_q.push_back(e);
        end
    end

    task automatic drive(input bit v, input logic [4:0] k, input bit h, input bit c);
        @(posedge clk);
        #1;
        giris_gecerli      = v;
        filtrelenmis_resim = k;
        cikis_hazir        = h;
        sayac_temizle      = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        model_on = 1'b0;
        #1;
        check("rst_cikis_gecerli", int'(cikis_gecerli), 0);
        check("rst_saf", int'(saf_resim), 0);
        check("rst_sayi", int'(hata_sayisi), 0);
        check("rst_hazir", int'(giris_hazir), 1);
        exp_q.delete();
        exp_darbe     = 1'b0;
        exp_cnt       = '0;
        giris_gecerli = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        model_on = 1'b1;
    endtask

    logic [4:0] legal_tab [5];

    initial begin
        n_test = 0;
        n_fail = 0;
        model_on = 1'b0;
        model_hazir = 1'b1;
        exp_darbe = 1'b0;
        exp_cnt = '0;
        legal_tab = '{5'd0, 5'd2, 5'd4, 5'd6, 5'd17};
        rst_n = 1'b0;
        giris_gecerli = 1'b0;
        filtrelenmis_resim = 5'd0;
        cikis_hazir = 1'b0;
        sayac_temizle = 1'b0;
        v2 = 1'b0;
        k2 = 5'd0;
        c2 = 1'b0;
        #12;
        check("init_cikis_gecerli", int'(cikis_gecerli), 0);
        check("init_sayi", int'(hata_sayisi), 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        model_on = 1'b1;

        // Every legal code, back to back, consumer always ready.
        foreach (legal_tab[i]) drive(1'b1, legal_tab[i], 1'b1, 1'b0);
        idle(3);

        // Illegal codes are dropped and counted.
        drive(1'b1, 5'd1, 1'b1, 1'b0);
        drive(1'b1, 5'd31, 1'b1, 1'b0);
        drive(1'b1, 5'd25, 1'b1, 1'b0);
        drive(1'b1, 5'd5, 1'b1, 1'b0);
        idle(2);
        check("sayac_4", int'(hata_sayisi), 4);

        // Back-pressure: only DERINLIK of six offers get in.
        drive(1'b1, 5'd0, 1'b0, 1'b0);
        drive(1'b1, 5'd2, 1'b0, 1'b0);
        drive(1'b1, 5'd4, 1'b0, 1'b0);
        drive(1'b1, 5'd6, 1'b0, 1'b0);
        drive(1'b1, 5'd17, 1'b0, 1'b0);
        drive(1'b1, 5'd2, 1'b0, 1'b0);
        idle(6);

        // Push while popping at occupancy 2, then run through pointer wrap.
        drive(1'b1, 5'd2, 1'b0, 1'b0);
        drive(1'b1, 5'd6, 1'b0, 1'b0);
        drive(1'b1, 5'd4, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, legal_tab[i % 5], 1'b1, 1'b0);
        idle(4);

        // Narrow counter instance: saturation and clear-over-increment.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            v2 = 1'b1;
            k2 = 5'd9;
        end
        @(posedge clk);
        #1;
        v2 = 1'b0;
        check("sat_sayi", int'(sayi2), 3);
        check("sat_darbe", int'(darbe2), 1);
        check("sat_bos", int'(cv2), 0);
        v2 = 1'b1;
        k2 = 5'd3;
        c2 = 1'b1;
        @(posedge clk);
        #1;
        v2 = 1'b0;
        c2 = 1'b0;
        check("clr_sayi", int'(sayi2), 0);
        check("clr_darbe", int'(darbe2), 1);
        @(posedge clk);
        #1;
        check("clr_darbe_end", int'(darbe2), 0);
        check("dut2_hazir", int'(hz2), 1);
        check("dut2_out", int'({saf2, doy2}), 0);

        // Reset with three entries queued and a nonzero error count.
        drive(1'b1, 5'd7, 1'b0, 1'b0);
        drive(1'b1, 5'd6, 1'b0, 1'b0);
        drive(1'b1, 5'd17, 1'b0, 1'b0);
        drive(1'b1, 5'd4, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 1'b0, 1'b0);
        mid_reset();
        drive(1'b1, 5'd2, 1'b1, 1'b0);
        idle(3);

        // Randomized traffic with bursts of stalls and occasional clears.
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] k;
            bit         h;
            if ($urandom_range(0, 3) == 0)
                k = 5'($urandom_range(0, 31));
            else
                k = legal_tab[$urandom_range(0, 4)];
            h = ((i / 64) % 3 == 2) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
            drive($urandom_range(0, 3) != 0, k, h, $urandom_range(0, 60) == 0);
        end

        idle(2 * D + 2);
        check("drain", exp_q.size(), 0);
        check("drain_gecerli", int'(cikis_gecerli), 0);
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
